// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment capture block: segment patterns,
// select/segment polarity, FSM encoding and small helpers.
package seven_segment_pkg;

  // Both anodes and segments are active-low on the display bus.
  localparam logic SEG_ON   = 1'b0;
  localparam logic ANODE_ON = 1'b0;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] ST_WAIT_SELECT = 2'd0;
  localparam logic [1:0] ST_SETTLING    = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       error;
  } seg_decode_t;

  function automatic seg_decode_t seg_digit(input logic [3:0] n);
    return '{nibble: n, blank: 1'b0, error: 1'b0};
  endfunction

  function automatic logic is_valid_select(input logic [3:0] en);
    return $countones(~en) == 1;
  endfunction

  function automatic logic [1:0] select_index(input logic [3:0] en);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (en[i] == ANODE_ON) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational segment-pattern to digit decoder. Hex letters A-F are
// recognised only when SEVEN_SEGMENT_CAPTURE_HEX_EN is defined.
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0]  pattern,
  output seg_decode_t result
);

  always_comb begin
    result = '{nibble: 4'hF, blank: 1'b0, error: 1'b1};
    case (pattern)
      SEG_0:     result = seg_digit(4'h0);
      SEG_1:     result = seg_digit(4'h1);
      SEG_2:     result = seg_digit(4'h2);
      SEG_3:     result = seg_digit(4'h3);
      SEG_4:     result = seg_digit(4'h4);
      SEG_5:     result = seg_digit(4'h5);
      SEG_6:     result = seg_digit(4'h6);
      SEG_7:     result = seg_digit(4'h7);
      SEG_8:     result = seg_digit(4'h8);
      SEG_9:     result = seg_digit(4'h9);
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_EN
      SEG_A:     result = seg_digit(4'hA);
      SEG_B:     result = seg_digit(4'hB);
      SEG_C:     result = seg_digit(4'hC);
      SEG_D:     result = seg_digit(4'hD);
      SEG_E:     result = seg_digit(4'hE);
      SEG_F:     result = seg_digit(4'hF);
`endif
      SEG_BLANK: result = '{nibble: 4'h0, blank: 1'b1, error: 1'b0};
      default:   result = '{nibble: 4'hF, blank: 1'b0, error: 1'b1};
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Captures a multiplexed seven-segment bus back into a four-digit frame.
// Optional hex decode via SEVEN_SEGMENT_CAPTURE_HEX_EN (see decoder).
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
)
(
  input  logic        cmosClock,
  input  logic        reset,
  input  logic [3:0]  sevenSegmentEnable,
  input  logic [7:0]  sevenSegmentData,
  output logic [15:0] digits,
  output logic [3:0]  digitBlank,
  output logic [3:0]  decimalPoints,
  output logic        frameValid,
  output logic        frameError
);

  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

  logic [3:0]  en_reg, en_prev_reg;
  logic [7:0]  data_reg, data_prev_reg;
  logic [1:0]  state_reg, state_next;
  logic [7:0]  stable_count_reg, stable_count_next;
  logic [7:0]  samples;
  logic        track;
  logic        write_en;
  logic        valid_sel, same_pair;
  logic [1:0]  sel_idx;
  seg_decode_t dec;
  logic [3:0]  seen_reg, write_mask, seen_set;
  logic        publish;
  logic [15:0] merged_nib;
  logic [3:0]  merged_blank, merged_dp, merged_err;

  assign valid_sel = is_valid_select(en_reg);
  assign same_pair = (en_reg == en_prev_reg) && (data_reg == data_prev_reg);
  assign sel_idx   = select_index(en_reg);

  seven_segment_decode u_decode (
    .pattern (data_reg[6:0]),
    .result  (dec)
  );

  always_ff @(posedge cmosClock) begin
    if (reset) begin
      en_reg        <= 4'hF;
      en_prev_reg   <= 4'hF;
      data_reg      <= 8'hFF;
      data_prev_reg <= 8'hFF;
    end else begin
      en_reg        <= sevenSegmentEnable;
      data_reg      <= sevenSegmentData;
      en_prev_reg   <= en_reg;
      data_prev_reg <= data_reg;
    end
  end

  // samples = length of the identical-pair run including the current sample;
  // the write fires the moment that run reaches SETTLE_CYCLES.
  always_comb begin
    state_next        = state_reg;
    stable_count_next = stable_count_reg;
    write_en          = 1'b0;
    samples           = 8'd0;
    track             = 1'b0;
    case (state_reg)
      ST_WAIT_SELECT: begin
        if (valid_sel) begin
          track   = 1'b1;
          samples = 8'd1;
        end
      end
      ST_SETTLING: begin
        if (!valid_sel) begin
          state_next        = ST_WAIT_SELECT;
          stable_count_next = 8'd0;
        end else begin
          track   = 1'b1;
          samples = !same_pair ? 8'd1 :
                    (stable_count_reg == 8'hFF) ? 8'hFF : stable_count_reg + 8'd1;
        end
      end
      ST_HELD: begin
        if (!same_pair) begin
          if (!valid_sel) begin
            state_next        = ST_WAIT_SELECT;
            stable_count_next = 8'd0;
          end else begin
            track   = 1'b1;
            samples = 8'd1;
          end
        end
      end
      default: begin
        state_next        = ST_WAIT_SELECT;
        stable_count_next = 8'd0;
      end
    endcase
    if (track) begin
      stable_count_next = samples;
      if (samples == SETTLE_N) begin
        write_en   = 1'b1;
        state_next = ST_HELD;
      end else begin
        state_next = ST_SETTLING;
      end
    end
  end

  always_ff @(posedge cmosClock) begin
    if (reset) begin
      state_reg        <= ST_WAIT_SELECT;
      stable_count_reg <= 8'd0;
    end else begin
      state_reg        <= state_next;
      stable_count_reg <= stable_count_next;
    end
  end

  // Merged views include the slot being written this edge, so the frame
  // published on the completing write already carries the newest digit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [3:0] nib_reg;
    logic       blank_reg, dp_reg, err_reg;

    assign write_mask[gi]         = write_en && (sel_idx == 2'(gi));
    assign merged_nib[4*gi +: 4]  = write_mask[gi] ? dec.nibble : nib_reg;
    assign merged_blank[gi]       = write_mask[gi] ? dec.blank  : blank_reg;
    assign merged_dp[gi]          = write_mask[gi] ? (data_reg[7] == SEG_ON) : dp_reg;
    assign merged_err[gi]         = write_mask[gi] ? dec.error  : err_reg;

    always_ff @(posedge cmosClock) begin
      if (reset) begin
        nib_reg   <= 4'h0;
        blank_reg <= 1'b0;
        dp_reg    <= 1'b0;
        err_reg   <= 1'b0;
      end else begin
        if (write_mask[gi]) begin
          nib_reg   <= dec.nibble;
          blank_reg <= dec.blank;
          dp_reg    <= data_reg[7] == SEG_ON;
        end
        err_reg <= publish ? 1'b0 : merged_err[gi];
      end
    end
  end

  assign seen_set = seen_reg | write_mask;
  assign publish  = write_en && (seen_set == 4'hF);

  always_ff @(posedge cmosClock) begin
    if (reset) begin
      digits        <= 16'h0000;
      digitBlank    <= 4'hF;
      decimalPoints <= 4'h0;
      frameValid    <= 1'b0;
      frameError    <= 1'b0;
      seen_reg      <= 4'h0;
    end else begin
      frameValid <= publish;
      if (publish) begin
        digits        <= merged_nib;
        digitBlank    <= merged_blank;
        decimalPoints <= merged_dp;
        frameError    <= |merged_err;
        seen_reg      <= 4'h0;
      end else begin
        seen_reg      <= seen_set;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: directed scenarios plus random
// dwells, checked against a run-length reference model of the display bus.
module tb_seven_segment_capture;

  localparam int SETTLE = 4;
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_EN
  localparam int HEX_LIM = 16;
`else
  localparam int HEX_LIM = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic [7:0]  dat;
  logic [15:0] digits;
  logic [3:0]  digit_blank, dps;
  logic        fv, fe;

  seven_segment_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .cmosClock          (clk),
    .reset              (rst),
    .sevenSegmentEnable (en),
    .sevenSegmentData   (dat),
    .digits             (digits),
    .digitBlank         (digit_blank),
    .decimalPoints      (dps),
    .frameValid         (fv),
    .frameError         (fe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] dg;
    logic [3:0]  bl;
    logic [3:0]  dp;
    logic        er;
  } frame_t;

  frame_t exp_q[$];
  int total = 0, bad = 0, frames_seen = 0;
  bit chk_reset = 0;
  bit prev_fv = 0;
  int neg_cnt = 0;

  logic [6:0] pat_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: a valid registered pair is captured when its run of
  // identical consecutive samples reaches exactly SETTLE.
  logic [11:0] m_reg = 12'hFFF, m_last = 12'hFFF;
  int          m_run = 0, m_cyc = 0;
  logic [3:0]  m_seen = 4'h0;
  logic [3:0]  m_nib [4];
  logic        m_bl [4], m_dp [4], m_er [4];

  task automatic model_write(input int idx, input logic [7:0] d);
    logic [3:0] nib;
    logic b, er;
    frame_t f;
    nib = 4'hF; b = 1'b0; er = 1'b1;
    if (d[6:0] == 7'h7F) begin
      nib = 4'h0; b = 1'b1; er = 1'b0;
    end else begin
      for (int i = 0; i < HEX_LIM; i++)
        if (pat_tbl[i] == d[6:0]) begin nib = 4'(i); er = 1'b0; end
    end
    m_nib[idx] = nib; m_bl[idx] = b; m_dp[idx] = ~d[7]; m_er[idx] = er;
    m_seen[idx] = 1'b1;
    if (m_seen == 4'hF) begin
      f.cyc = m_cyc;
      f.dg  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      f.bl  = {m_bl[3], m_bl[2], m_bl[1], m_bl[0]};
      f.dp  = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
      f.er  = m_er[0] | m_er[1] | m_er[2] | m_er[3];
      exp_q.push_back(f);
      m_seen = 4'h0;
      for (int i = 0; i < 4; i++) m_er[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [3:0] e, input logic [7:0] d, input logic r);
    logic [11:0] cur;
    int idx;
    m_cyc++;
    if (r) begin
      m_seen = 4'h0; m_run = 0; m_last = 12'hFFF; m_reg = 12'hFFF;
      for (int i = 0; i < 4; i++) m_er[i] = 1'b0;
      chk_reset = 1;
      return;
    end
    cur = m_reg;
    if ($countones(~cur[11:8]) == 1) begin
      m_run = (cur == m_last) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
      if (m_run == SETTLE) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!cur[8+i]) idx = i;
        model_write(idx, cur[7:0]);
      end
    end else begin
      m_run = 0;
    end
    m_last = cur;
    m_reg  = {e, d};
  endtask

  task automatic step(input logic [3:0] e, input logic [7:0] d, input logic r);
    en = e; dat = d; rst = r;
    @(posedge clk);
    model_edge(e, d, r);
    #1;
  endtask

  task automatic dwell(input logic [3:0] e, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) step(e, d, 1'b0);
  endtask

  always @(negedge clk) begin
    frame_t f;
    neg_cnt++;
    if (chk_reset) begin
      chk_reset = 0;
      total++;
      if (digits !== 16'h0 || digit_blank !== 4'hF || dps !== 4'h0 || fv !== 1'b0 || fe !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got digits=%h blank=%h dp=%h fv=%b fe=%b, want 0000/f/0/0/0",
                 digits, digit_blank, dps, fv, fe);
      end
    end else if (fv !== 1'b0) begin
      frames_seen++;
      total++;
      if (prev_fv) begin
        bad++;
        $display("FAIL back_to_back: frameValid high two cycles running at cycle %0d", neg_cnt);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: got frameValid=%b at cycle %0d, want no frame", fv, neg_cnt);
      end else begin
        f = exp_q.pop_front();
        total += 4;
        if (f.cyc != neg_cnt) begin bad++; $display("FAIL frame_cycle: got %0d want %0d", neg_cnt, f.cyc); end
        if (digits !== f.dg) begin bad++; $display("FAIL digits: got %h want %h", digits, f.dg); end
        if (digit_blank !== f.bl || dps !== f.dp) begin
          bad++; $display("FAIL blank_dp: got %h/%h want %h/%h", digit_blank, dps, f.bl, f.dp);
        end
        if (fe !== f.er) begin bad++; $display("FAIL frame_error: got %b want %b", fe, f.er); end
        $display("frame %0d cyc=%0d digits=%h blank=%h dp=%h err=%b",
                 frames_seen, neg_cnt, digits, digit_blank, dps, fe);
      end
    end
    prev_fv = (fv === 1'b1);
  end

  initial begin
    logic [3:0] e;
    logic [6:0] p;
    int k;
    step(4'hF, 8'hFF, 1'b1);
    step(4'hF, 8'hFF, 1'b1);

    // basic frame with a glitch between dwells
    dwell(4'hE, 8'hC0, 8);
    dwell(4'hE, 8'h88, 2);
    dwell(4'hD, 8'hF9, 8);
    dwell(4'hB, 8'hA4, 8);
    dwell(4'h7, 8'hB0, 8);

    // blank digit 3, dp lit on digit 0, hex-or-error on digit 2
    dwell(4'h7, 8'hFF, 6);
    dwell(4'hE, 8'h40, 6);
    dwell(4'hB, 8'h88, 6);
    dwell(4'hD, 8'h79, 6);

    // invalid select, then partial frame discarded by reset
    dwell(4'hC, 8'hC0, 10);
    dwell(4'hE, 8'hC0, 6);
    dwell(4'hD, 8'hA4, 6);
    dwell(4'hB, 8'hB0, 6);
    step(4'hB, 8'hB0, 1'b1);
    dwell(4'h7, 8'h99, 6);
    dwell(4'hF, 8'hFF, 3);

    // re-capture of digit 0 before completion, then a one-sample dwell
    dwell(4'hE, 8'hF9, 6);
    dwell(4'hE, 8'hB0, 6);
    dwell(4'hD, 8'h92, 6);
    dwell(4'hB, 8'h82, 1);
    dwell(4'hB, 8'hF8, 300);
    dwell(4'h7, 8'h80, 6);
    dwell(4'hE, 8'h90, 5);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        dwell(4'hF, 8'hFF, 0);
        step(en, dat, 1'b1);
      end
      e = ($urandom_range(0, 99) < 85) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      k = $urandom_range(0, 19);
      if (k < 10) p = pat_tbl[k];
      else if (k < 12) p = 7'h7F;
      else if (k < 16) p = pat_tbl[$urandom_range(10, 15)];
      else p = 7'($urandom);
      dwell(e, {1'($urandom), p}, $urandom_range(1, 10));
    end

    dwell(4'hF, 8'hFF, 4);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_frames: got %0d outstanding, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
